// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the icache and dcache miss engines.
// Sequences whole-line reads (fills) and writebacks, returning fill beats to the granted cache.
module mem_bus_arbiter #(
  parameter int              ADDR_W = 64,
  parameter int              DATA_W = 64,
  parameter int              TAG_W  = 13,
  parameter int              BEATS  = 8,
  parameter logic [TAG_W-1:0] TAG_RD = 13'h1100,
  parameter logic [TAG_W-1:0] TAG_WR = 13'h1200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic                      i_wr,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic [BEATS*DATA_W-1:0]   i_wdata,
  output logic                      i_rvalid,
  output logic                      i_done,
  input  logic                      d_req,
  input  logic                      d_wr,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [BEATS*DATA_W-1:0]   d_wdata,
  output logic                      d_rvalid,
  output logic                      d_done,
  output logic [DATA_W-1:0]         rdata,
  output logic [$clog2(BEATS)-1:0]  rbeat,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [DATA_W-1:0]         bus_req,
  output logic [TAG_W-1:0]          bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [DATA_W-1:0]         bus_resp,
  input  logic [TAG_W-1:0]          bus_resptag
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(BEATS * DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, DONE} state_t;

  state_t            state_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic              last_grant_reg;  // 1 = dcache
  logic              grant_reg;
  logic              wr_reg;

  logic [DATA_W-1:0] i_beat [BEATS];
  logic [DATA_W-1:0] d_beat [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beats
      assign i_beat[gi] = i_wdata[gi*DATA_W +: DATA_W];
      assign d_beat[gi] = d_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic              grant_pick;
  logic              pick_wr;
  logic [ADDR_W-1:0] pick_addr;
  logic [BEAT_W-1:0] beat_next;
  logic              last_beat;

  always_comb begin
    grant_pick = (i_req && d_req) ? !last_grant_reg : d_req;
    pick_wr    = grant_pick ? d_wr : i_wr;
    pick_addr  = (grant_pick ? d_addr : i_addr) & LINE_MASK;
    beat_next  = beat_reg + BEAT_W'(1);
    last_beat  = (beat_reg == LAST_BEAT);
  end

  // Fill beats are only taken while waiting for them and only with the read tag.
  assign bus_respack = (state_reg == RWAIT) && bus_respcyc && (bus_resptag == TAG_RD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      wr_reg         <= 1'b0;
      i_rvalid       <= 1'b0;
      d_rvalid       <= 1'b0;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
      rdata          <= '0;
      rbeat          <= '0;
      bus_reqcyc     <= 1'b0;
      bus_req        <= '0;
      bus_reqtag     <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_req || d_req) begin
            grant_reg      <= grant_pick;
            last_grant_reg <= grant_pick;
            wr_reg         <= pick_wr;
            bus_reqcyc     <= 1'b1;
            bus_req        <= DATA_W'(pick_addr);
            bus_reqtag     <= pick_wr ? TAG_WR : TAG_RD;
            state_reg      <= ADDR;
          end
        end
        ADDR: begin
          if (bus_reqack) begin
            beat_reg <= '0;
            if (wr_reg) begin
              bus_req    <= grant_reg ? d_beat[0] : i_beat[0];
              bus_reqtag <= TAG_WR;
              state_reg  <= WDATA;
            end else begin
              bus_reqcyc <= 1'b0;
              bus_req    <= '0;
              bus_reqtag <= '0;
              state_reg  <= RWAIT;
            end
          end
        end
        WDATA: begin
          if (bus_reqack) begin
            if (last_beat) begin
              beat_reg   <= '0;
              bus_reqcyc <= 1'b0;
              bus_req    <= '0;
              bus_reqtag <= '0;
              d_done     <= grant_reg;
              i_done     <= !grant_reg;
              state_reg  <= DONE;
            end else begin
              beat_reg <= beat_next;
              bus_req  <= grant_reg ? d_beat[beat_next] : i_beat[beat_next];
            end
          end
        end
        RWAIT: begin
          if (bus_respack) begin
            rdata    <= bus_resp;
            rbeat    <= beat_reg;
            d_rvalid <= grant_reg;
            i_rvalid <= !grant_reg;
            beat_reg <= beat_next;
            // Last fill beat and the done pulse appear in the same cycle.
            if (last_beat) begin
              d_done    <= grant_reg;
              i_done    <= !grant_reg;
              state_reg <= DONE;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected bus words,
// fill beats and done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_bus_arbiter;

  localparam int          BEATS  = 8;
  localparam logic [12:0] TAG_RD = 13'h1100;
  localparam logic [12:0] TAG_WR = 13'h1200;
  localparam int EV_REQ = 0, EV_FILL = 1, EV_DONE = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req, i_wr, d_req, d_wr;
  logic [63:0]  i_addr, d_addr;
  logic [511:0] i_wdata, d_wdata;
  logic         i_rvalid, i_done, d_rvalid, d_done;
  logic [63:0]  rdata;
  logic [2:0]   rbeat;
  logic         bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0]  bus_req, bus_resp;
  logic [12:0]  bus_reqtag, bus_resptag;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int          kind;
    int          cache;
    logic [63:0] data;
    logic [12:0] tag;
    int          beat;
    bit          done;
  } ev_t;
  ev_t exp_q[$];

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_done(d_done),
    .rdata(rdata), .rbeat(rbeat),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int cache, input logic [63:0] data,
                      input logic [12:0] tag, input int beat, input bit done);
    ev_t e;
    e.kind = kind; e.cache = cache; e.data = data; e.tag = tag; e.beat = beat; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input int cache, input logic [63:0] data,
                         input logic [12:0] tag, input int beat, input bit done);
    ev_t e;
    bit bad;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL unexpected_event: got kind=%0d cache=%0d data=%h tag=%h beat=%0d, expected nothing",
               kind, cache, data, tag, beat);
      return;
    end
    e = exp_q.pop_front();
    bad = (e.kind != kind) || (e.cache != cache) || (e.data !== data) || (e.beat != beat) ||
          (e.done != done) || (kind == EV_REQ && e.tag !== tag);
    if (bad) begin
      tests_failed++;
      $display("FAIL scoreboard: got kind=%0d cache=%0d data=%h tag=%h beat=%0d done=%0d, expected kind=%0d cache=%0d data=%h tag=%h beat=%0d done=%0d",
               kind, cache, data, tag, beat, done, e.kind, e.cache, e.data, e.tag, e.beat, e.done);
    end
  endtask

  // Monitor: every accepted request word, fill beat and done pulse must match the queue head.
  always @(negedge clk) begin
    if (bus_reqcyc && bus_reqack)
      pop_cmp(EV_REQ, 0, bus_req, bus_reqtag, 0, 1'b0);
    if (i_rvalid && d_rvalid)
      check("both_rvalid", 64'd1, 64'd0);
    if (i_rvalid || d_rvalid)
      pop_cmp(EV_FILL, d_rvalid ? 1 : 0, rdata, 13'h0, int'(rbeat), d_rvalid ? d_done : i_done);
    else if (i_done || d_done)
      pop_cmp(EV_DONE, d_done ? 1 : 0, 64'h0, 13'h0, 0, 1'b1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_word(input int dly);
    for (int n = 0; n < 50 && !bus_reqcyc; n++) cyc();
    if (!bus_reqcyc) begin
      check("reqcyc_timeout", 64'd0, 64'd1);
      return;
    end
    repeat (dly) cyc();
    bus_reqack = 1'b1;
    cyc();
    bus_reqack = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_reqcyc"},  {63'd0, bus_reqcyc}, 64'd0);
    check({tag, "_req"},     bus_req, 64'd0);
    check({tag, "_reqtag"},  {51'd0, bus_reqtag}, 64'd0);
    check({tag, "_rvalid"},  {62'd0, i_rvalid, d_rvalid}, 64'd0);
    check({tag, "_done"},    {62'd0, i_done, d_done}, 64'd0);
    check({tag, "_rdata"},   rdata, 64'd0);
    check({tag, "_rbeat"},   {61'd0, rbeat}, 64'd0);
    check({tag, "_respack"}, {63'd0, bus_respack}, 64'd0);
  endtask

  // Serves one read the DUT has been (or is about to be) granted; req is raised by the caller.
  task automatic serve_read(input int cache, input logic [63:0] line, input logic [63:0] base,
                            input bit keep, input int wrong_at, input int stop_after);
    push(EV_REQ, 0, line, TAG_RD, 0, 1'b0);
    for (int k = 0; k < stop_after; k++)
      push(EV_FILL, cache, base + 64'(k), 13'h0, k, k == BEATS - 1);
    ack_word(0);
    for (int k = 0; k < stop_after; k++) begin
      if (k == wrong_at) begin
        bus_respcyc = 1'b1; bus_resptag = TAG_WR; bus_resp = 64'hDEAD;
        #1 check("wrong_tag_respack", {63'd0, bus_respack}, 64'd0);
        cyc();
      end
      bus_respcyc = 1'b1; bus_resptag = TAG_RD; bus_resp = base + 64'(k);
      #1 check("fill_respack", {63'd0, bus_respack}, 64'd1);
      cyc();
    end
    bus_respcyc = 1'b0;
    bus_resptag = '0;
    if (!keep && stop_after == BEATS) begin
      if (cache == 1) d_req = 1'b0;
      else            i_req = 1'b0;
    end
    $display("[TB] read %s line %h, %0d beats from %h", cache ? "dcache" : "icache",
             line, stop_after, base);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    i_req = 0; i_wr = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    repeat (3) cyc();
    check_idle_outputs("reset");
    reset = 1'b1;
    cyc();

    // Icache read alone, unaligned address.
    i_req = 1; i_addr = 64'h1047;
    serve_read(0, 64'h1040, 64'hA0, 1'b0, -1, BEATS);
    repeat (2) cyc();

    // Tie after reset: icache first; icache keeps requesting, so the next tie goes to dcache.
    reset = 1'b0; cyc(); reset = 1'b1; cyc();
    i_req = 1; i_addr = 64'h3000; d_req = 1; d_addr = 64'h4008;
    serve_read(0, 64'h3000, 64'hB0, 1'b1, -1, BEATS);
    i_addr = 64'h5000;
    serve_read(1, 64'h4000, 64'hC0, 1'b0, -1, BEATS);
    serve_read(0, 64'h5000, 64'hD0, 1'b0, -1, BEATS);
    repeat (2) cyc();

    // Dcache writeback with randomly delayed acks.
    for (int k = 0; k < BEATS; k++) d_wdata[k*64 +: 64] = 64'h11 * 64'(k + 1);
    d_req = 1; d_wr = 1; d_addr = 64'h2000;
    push(EV_REQ, 0, 64'h2000, TAG_WR, 0, 1'b0);
    for (int k = 0; k < BEATS; k++) push(EV_REQ, 0, 64'h11 * 64'(k + 1), TAG_WR, 0, 1'b0);
    push(EV_DONE, 1, 64'h0, 13'h0, 0, 1'b1);
    for (int k = 0; k <= BEATS; k++) ack_word($urandom_range(0, 3));
    d_req = 0; d_wr = 0;
    $display("[TB] write dcache line 0000000000002000, %0d beats", BEATS);
    repeat (3) cyc();

    // Stray response beat while idle, then a wrong-tag beat in the middle of a fill.
    bus_respcyc = 1; bus_resptag = TAG_RD; bus_resp = 64'h99;
    #1 check("stray_idle_respack", {63'd0, bus_respack}, 64'd0);
    repeat (3) cyc();
    bus_respcyc = 0;
    $display("[TB] stray response beat in idle");
    d_req = 1; d_addr = 64'h6010;
    serve_read(1, 64'h6000, 64'hE0, 1'b0, 3, BEATS);
    repeat (2) cyc();

    // Reset after three fill beats aborts the fill; a fresh fill then completes normally.
    i_req = 1; i_addr = 64'h7000;
    serve_read(0, 64'h7000, 64'hF0, 1'b0, -1, 3);
    reset = 1'b0; i_req = 0;
    cyc();
    check_idle_outputs("abort");
    reset = 1'b1;
    cyc();
    $display("[TB] reset during fill");
    i_req = 1; i_addr = 64'h8000;
    serve_read(0, 64'h8000, 64'h50, 1'b0, -1, BEATS);
    repeat (4) cyc();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
